// File: rtl/dotprod_vec_loader.sv
// Operand loader for dotprod: streams (a,b) pairs into operand memory, launches a job, serves reads.
// Optional double-buffering under DOTPROD_LOADER_PINGPONG_EN.
module dotprod_vec_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  input  logic              s_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic              start,
  output logic [DATA_W-1:0] n,
  input  logic              done,
  output logic              busy,
  output logic              ovf_err
);

  typedef enum logic [2:0] {FILL, DROP, LAUNCH, WAIT, PEND} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              take;
  logic              blocked;

`ifdef DOTPROD_LOADER_PINGPONG_EN
  localparam int MEM_AW = ADDR_W + 1;
  logic              wr_bank, rd_bank;
  logic [MEM_AW-1:0] wr_idx, rd_idx;
  assign wr_idx  = {wr_bank, wr_ptr};
  assign rd_idx  = {rd_bank, rd_addr};
  // A completed vector must wait while the other bank is still being read.
  assign blocked = busy && !done;
`else
  localparam int MEM_AW = ADDR_W;
  logic [MEM_AW-1:0] wr_idx, rd_idx;
  assign wr_idx  = wr_ptr;
  assign rd_idx  = rd_addr;
  assign blocked = 1'b0;
`endif

  logic [DATA_W-1:0] a_mem [2**MEM_AW];
  logic [DATA_W-1:0] b_mem [2**MEM_AW];

  assign s_ready = (state == FILL) || (state == DROP);
  assign take    = s_valid && s_ready;
  assign rd_a    = a_mem[rd_idx];
  assign rd_b    = b_mem[rd_idx];

  // Only beats that fit are stored; DROP discards overflow beats.
  always_ff @(posedge sys_clk) begin
    if (take && state == FILL) begin
      a_mem[wr_idx] <= s_a;
      b_mem[wr_idx] <= s_b;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= FILL;
      wr_ptr  <= '0;
      start   <= 1'b0;
      n       <= '0;
      busy    <= 1'b0;
      ovf_err <= 1'b0;
`ifdef DOTPROD_LOADER_PINGPONG_EN
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
`ifdef DOTPROD_LOADER_PINGPONG_EN
      if (done && (state == FILL || state == DROP)) busy <= 1'b0;
`endif
      case (state)
        FILL: if (take) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (s_last) begin
            n <= DATA_W'(wr_ptr) + DATA_W'(1);
            if (blocked) state <= PEND;
            else begin
              state <= LAUNCH;
              start <= 1'b1;
            end
          end else if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
            n       <= DATA_W'(DEPTH);
            ovf_err <= 1'b1;
            state   <= DROP;
          end
        end
        DROP: if (take && s_last) begin
          if (blocked) state <= PEND;
          else begin
            state <= LAUNCH;
            start <= 1'b1;
          end
        end
        LAUNCH: begin
          busy   <= 1'b1;
          wr_ptr <= '0;
`ifdef DOTPROD_LOADER_PINGPONG_EN
          rd_bank <= wr_bank;
          wr_bank <= ~wr_bank;
          state   <= FILL;
`else
          state   <= WAIT;
`endif
        end
        WAIT: if (done) begin
          busy  <= 1'b0;
          state <= FILL;
        end
        PEND: if (done) begin
          busy  <= 1'b0;
          state <= LAUNCH;
          start <= 1'b1;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_dotprod_vec_loader.sv
module tb_dotprod_vec_loader;
  localparam int DW = 32, DEPTH = 256, AW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1, s_valid = 1'b0, s_last = 1'b0, done = 1'b0;
  logic [DW-1:0] s_a = '0, s_b = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          s_ready, start, busy, ovf_err;
  logic [DW-1:0] rd_a, rd_b, n;

  int checks = 0, errors = 0;
  logic [DW-1:0] va [300];
  logic [DW-1:0] vb [300];
  logic [DW-1:0] ma [DEPTH];
  logic [DW-1:0] mb [DEPTH];
  logic [DW-1:0] exp_n;
  logic [DW-1:0] keep_a;

  dotprod_vec_loader #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_last(s_last), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
    .start(start), .n(n), .done(done), .busy(busy), .ovf_err(ovf_err));

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string t, input logic [DW-1:0] o, input logic [DW-1:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic model_vec(input int len);
    for (int i = 0; i < len; i++)
      if (i < DEPTH) begin
        ma[i] = va[i];
        mb[i] = vb[i];
      end
    exp_n = (len > DEPTH) ? DW'(DEPTH) : DW'(len);
  endtask

  task automatic rand_vec(input int len);
    for (int i = 0; i < len; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
    model_vec(len);
  endtask

  task automatic send(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        tick();
      end
      chk("s_ready_load", s_ready, 1'b1);
      s_valid = 1'b1; s_a = va[i]; s_b = vb[i]; s_last = (i == len - 1);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic check_reads(input int cnt);
    int addr;
    for (int k = 0; k < cnt; k++) begin
      addr = (k == 0) ? int'(exp_n) - 1 : $urandom_range(0, int'(exp_n) - 1);
      rd_addr = AW'(addr);
      #1;
      chk("rd_a", rd_a, ma[addr]);
      chk("rd_b", rd_b, mb[addr]);
    end
  endtask

  task automatic check_launch();
    chk("start_pulse", start, 1'b1);
    chk("n", n, exp_n);
    chk("s_ready_launch", s_ready, 1'b0);
    tick();
    chk("start_low", start, 1'b0);
    chk("busy_set", busy, 1'b1);
  endtask

  task automatic finish_job();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("s_ready_after_done", s_ready, 1'b1);
    chk("busy_clear", busy, 1'b0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_start", start, 1'b0);
    chk("rst_n", n, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf_err, 1'b0);
    sys_rst = 1'b0;
    tick();

`ifdef DOTPROD_LOADER_PINGPONG_EN
    rand_vec(3);
    keep_a = va[0];
    send(3, 1'b0);
    check_launch();
    chk("pp_fill_while_busy", s_ready, 1'b1);
    rand_vec(2);
    send(2, 1'b0);
    chk("pp_pend_no_start", start, 1'b0);
    chk("pp_pend_ready", s_ready, 1'b0);
    rd_addr = '0;
    #1;
    chk("pp_read_old_bank", rd_a, keep_a);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_launch();
    check_reads(2);
`else
    for (int i = 0; i < 4; i++) begin
      va[i] = DW'(i + 1);
      vb[i] = DW'(i + 5);
    end
    model_vec(4);
    send(4, 1'b0);
    chk("start_latency", start, 1'b1);
    rd_addr = 8'd2;
    #1;
    chk("t1_rd_a", rd_a, 32'd3);
    chk("t1_rd_b", rd_b, 32'd7);
    check_launch();

    s_valid = 1'b1; s_last = 1'b1; s_a = ~va[0]; s_b = ~vb[0];
    #1;
    chk("wait_s_ready", s_ready, 1'b0);
    tick(); tick();
    chk("wait_no_start", start, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    check_reads(4);
    finish_job();

    rand_vec(260);
    send(260, 1'b0);
    chk("ovf_err_set", ovf_err, 1'b1);
    rd_addr = 8'd255;
    #1;
    chk("ovf_mem255_a", rd_a, va[255]);
    chk("ovf_mem255_b", rd_b, vb[255]);
    check_launch();
    check_reads(5);
    finish_job();

    for (int v = 0; v < 4; v++) begin
      int len;
      len = (v == 0) ? DEPTH : $urandom_range(1, DEPTH);
      rand_vec(len);
      send(len, 1'b1);
      check_launch();
      check_reads(6);
      finish_job();
    end
    chk("ovf_sticky", ovf_err, 1'b1);

    rand_vec(1);
    send(1, 1'b0);
    check_launch();
    check_reads(1);
    finish_job();

    rand_vec(2);
    send(2, 1'b0);
    check_launch();
    sys_rst = 1'b1;
    tick();
    chk("midrst_start", start, 1'b0);
    chk("midrst_n", n, 32'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ovf", ovf_err, 1'b0);
    sys_rst = 1'b0;
    tick();
    chk("midrst_ready", s_ready, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("late_done_busy", busy, 1'b0);
    chk("late_done_ready", s_ready, 1'b1);
    chk("late_done_start", start, 1'b0);
    chk("late_done_n", n, 32'd0);
    rand_vec(5);
    send(5, 1'b1);
    check_launch();
    check_reads(3);
    finish_job();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
